// File: rtl/alu_pkg.sv
// ALU execution unit shared definitions: control codes,
// top FSM encoding and the mult/div engine mode.
package alu_pkg;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_MULT = 4'b0011;
    localparam logic [3:0] ALU_DIV  = 4'b0100;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_MUL  = 2'b01;
    localparam logic [1:0] S_DIV  = 2'b10;
    localparam logic [1:0] S_FIX  = 2'b11;

    typedef enum logic {
        MD_MUL = 1'b0,
        MD_DIV = 1'b1
    } md_mode_e;

endpackage

// File: rtl/alu_muldiv.sv
// Iterative signed multiply / restoring divide engine.
// Works on magnitudes; signs are reapplied on the output.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go_i,
    input  md_mode_e         mode_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             ready_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    localparam int CW = $clog2(WIDTH);

    md_mode_e           mode_q;
    logic               neg_q;
    logic               rneg_q;
    logic               run_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH-1:0]   m_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic [WIDTH-1:0]   hi_d;
    logic [WIDTH-1:0]   lo_d;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     addv;
    logic [WIDTH:0]     shl;
    logic               ge;
    logic [2*WIDTH-1:0] prod;

    assign a_mag = a_i[WIDTH-1] ? -a_i : a_i;
    assign b_mag = b_i[WIDTH-1] ? -b_i : b_i;

    // Ready marks the final iteration, so the caller can
    // move to its fixup state on the same edge.
    assign ready_o = run_q && (cnt_q == '0);

    always_comb begin
        sum  = {1'b0, hi_q} + {1'b0, m_q};
        addv = lo_q[0] ? sum : {1'b0, hi_q};
        shl  = {hi_q, lo_q[WIDTH-1]};
        ge   = shl >= {1'b0, m_q};
        diff = shl[WIDTH-1:0] - m_q;
        if (mode_q == MD_MUL) begin
            hi_d = addv[WIDTH:1];
            lo_d = {addv[0], lo_q[WIDTH-1:1]};
        end else begin
            hi_d = ge ? diff : shl[WIDTH-1:0];
            lo_d = {lo_q[WIDTH-2:0], ge};
        end
    end

    always_comb begin
        prod = {hi_q, lo_q};
        if (neg_q) prod = -prod;
        if (mode_q == MD_MUL) begin
            hi_o = prod[2*WIDTH-1:WIDTH];
            lo_o = prod[WIDTH-1:0];
        end else begin
            hi_o = rneg_q ? -hi_q : hi_q;
            lo_o = neg_q ? -lo_q : lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q <= MD_MUL;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            run_q  <= 1'b0;
            cnt_q  <= '0;
            m_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (go_i) begin
            mode_q <= mode_i;
            neg_q  <= a_i[WIDTH-1] ^ b_i[WIDTH-1];
            rneg_q <= a_i[WIDTH-1];
            m_q    <= (mode_i == MD_MUL) ? a_mag : b_mag;
            lo_q   <= (mode_i == MD_MUL) ? b_mag : a_mag;
            hi_q   <= '0;
            cnt_q  <= CW'(WIDTH - 1);
            run_q  <= 1'b1;
        end else if (run_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q - CW'(1);
            run_q <= (cnt_q != '0);
        end
    end

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arith ops plus
// a start/busy/done handshake around the mult/div engine.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       control,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             err
);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zero_q, zero_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic             idle;
    logic             md_go;
    logic             md_ready;
    md_mode_e         md_mode;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;
    logic [WIDTH-1:0] alu_res;
    logic             alu_wr;

    assign idle    = (state_q == S_IDLE);
    assign md_mode = (control == ALU_DIV) ? MD_DIV : MD_MUL;
    assign md_go   = idle && start &&
                     ((control == ALU_MULT) ||
                      ((control == ALU_DIV) && (b != '0)));

    alu_muldiv #(
        .WIDTH (WIDTH)
    ) u_muldiv (
        .clk     (clk),
        .rst_n   (rst_n),
        .go_i    (md_go),
        .mode_i  (md_mode),
        .a_i     (a),
        .b_i     (b),
        .ready_o (md_ready),
        .hi_o    (md_hi),
        .lo_o    (md_lo)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        err_d    = err_q;
        done_d   = 1'b0;
        alu_res  = '0;
        alu_wr   = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                err_d  = 1'b0;
                alu_wr = 1'b1;
                case (control)
                    ALU_AND: alu_res = a & b;
                    ALU_OR:  alu_res = a | b;
                    ALU_ADD: alu_res = a + b;
                    ALU_SUB: alu_res = a - b;
                    ALU_SLT: alu_res = {{(WIDTH-1){1'b0}},
                                        $signed(a) < $signed(b)};
                    ALU_MULT: begin
                        alu_wr  = 1'b0;
                        state_d = S_MUL;
                    end
                    // Divide by zero completes at once with a flagged result.
                    ALU_DIV: if (b == '0) begin
                        alu_res = '1;
                        hi_d    = a;
                        lo_d    = '1;
                        err_d   = 1'b1;
                    end else begin
                        alu_wr  = 1'b0;
                        state_d = S_DIV;
                    end
                    default: err_d = 1'b1;
                endcase
            end
            S_MUL, S_DIV: if (md_ready) state_d = S_FIX;
            S_FIX: begin
                alu_res = md_lo;
                alu_wr  = 1'b1;
                hi_d    = md_hi;
                lo_d    = md_lo;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (alu_wr) begin
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign result = result_q;
    assign zero   = zero_q;
    assign hi     = hi_q;
    assign lo     = lo_q;
    assign busy   = !idle;
    assign done   = done_q;
    assign err    = err_q;

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
Execution-side consumer of the 4-bit ALU control code produced by the ALU control decoder. It executes the selected operation on two operands. AND, OR, add, sub and slt finish in one registered cycle. mult and div run as an iterative multicycle engine that writes the HI/LO pair. A start/busy/done handshake lets the datapath controller stall the pipeline on mult/div.

Parameters:
WIDTH, 32, operand/result width in bits (even, >= 4)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  launch operation; sampled with control/a/b while idle
control  in  4  ALU control code: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt, 0011 mult, 0100 div
a  in  WIDTH  operand A (rs); dividend for div
b  in  WIDTH  operand B (rt/imm); divisor for div
result  out  WIDTH  registered result; for mult/div equals LO
zero  out  1  registered (result == 0), updated with result
hi  out  WIDTH  HI register: product upper half or remainder
lo  out  WIDTH  LO register: product lower half or quotient
busy  out  1  multicycle operation in progress
done  out  1  one-cycle pulse; result/zero/hi/lo/err valid and stable from this cycle
err  out  1  registered with done: illegal control code or divide by zero

Behaviour:
- Reset (async assert, sync release): result, zero, hi, lo, busy, done, err = 0; FSM = IDLE.
- Reset mid-operation aborts the operation. No done is produced for the aborted operation.
- FSM states: IDLE, MUL, DIV, FIX.
- start is honoured only in IDLE. start while busy is ignored and has no side effects.
- Single-cycle ops (start at edge k):
  - result/zero update at edge k+1; done = 1 for the cycle after k+1; busy stays 0.
  - add/sub wrap modulo 2^WIDTH; no overflow trap.
  - slt is signed: result = 1 if $signed(a) < $signed(b), else 0.
  - hi/lo unchanged.
- mult (0011), signed:
  - IDLE -> MUL: latch |a|, |b| and the result sign.
  - MUL: WIDTH shift-add iterations, counter WIDTH-1 down to 0.
  - FIX: negate the 2*WIDTH product if the sign is set; {hi, lo} = product; result = lo.
  - done at edge k+WIDTH+2; busy high for the WIDTH+1 cycles between start and done.
- div (0100), signed restoring division, truncation toward zero:
  - IDLE -> DIV: WIDTH iterations, then FIX.
  - lo = quotient; hi = remainder; remainder sign follows dividend.
  - Same latency as mult.
  - Special case: a = most-negative, b = -1 -> lo = a (wraps), hi = 0, err = 0.
- Divide by zero (b == 0):
  - No iteration: hi = a, lo = all ones, result = lo, err = 1.
  - done at edge k+1; busy never asserts.
- Illegal control (any other code): result = 0, zero = 1, err = 1, hi/lo unchanged, done at edge k+1.
- err is cleared on the next accepted start.
- done is a single-cycle pulse. result/zero/hi/lo hold until the next operation writes them.
- Back-to-back: a start may be issued in the same cycle done is high (the FSM is in IDLE then) and is accepted.
- control, a and b may change freely after acceptance; the operands are latched.

Decomposition:
- Shared package alu_pkg holds:
  - control-code constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_MULT, ALU_DIV;
  - the FSM state encoding.
  - The ALU control decoder imports the same constants so both ends agree.
- One sub-module, alu_muldiv. It contains the iterative mult/div datapath: magnitude conversion, shift register pair, counter and sign fixup. It uses a go/mode/ready interface.
- alu_exec_unit keeps the single-cycle path, the top FSM/handshake and the output registers.

Test Plan:
- add: a=7, b=FFFFFFFD, control=0010, start 1 cycle -> result=00000004, zero=0, done 1 cycle after start, busy never high.
- sub/slt: a=b=5, 0110 -> result=0, zero=1. Then a=FFFFFFFF, b=00000001, 0111 -> result=1. Then a=1, b=FFFFFFFF -> result=0.
- mult: a=FFFFFFFE, b=00000003, 0011 -> hi=FFFFFFFF, lo=FFFFFFFA, result=FFFFFFFA. done exactly 34 cycles after start; busy high 33 cycles. A start pulsed at cycle 10 is ignored.
- div: a=FFFFFFF9, b=00000002, 0100 -> lo=FFFFFFFD, hi=FFFFFFFF, err=0, latency 34. Then a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
- errors: div a=9, b=0 -> hi=9, lo=FFFFFFFF, err=1, done after 1 cycle. Then control=1111 -> result=0, zero=1, err=1, hi/lo unchanged.
- reset: rst_n low at cycle 10 of a mult -> all outputs 0 immediately (async), no done. After release, add 2+2 -> result=4, done after 1 cycle.
